// File: rtl/pic_pkg.sv
// Shared constants, opcode patterns and decode helpers for the PIC16-style fetch path.
package pic_pkg;

    localparam int unsigned PIC_ADDR_W  = 11;
    localparam int unsigned PIC_INSTR_W = 14;

    localparam logic [PIC_INSTR_W-1:0] OP_NOP    = 14'h0000;
    localparam logic [PIC_INSTR_W-1:0] OP_RETURN = 14'h0008;
    localparam logic [PIC_INSTR_W-1:0] OP_RETFIE = 14'h0009;

    // Opcode field values matched against the top bits of the instruction word.
    localparam logic [2:0] OP_GOTO_HI  = 3'b101;
    localparam logic [2:0] OP_CALL_HI  = 3'b100;
    localparam logic [3:0] OP_RETLW_HI = 4'b1101;

    typedef enum logic {
        FILL,
        RUN
    } fetch_state_e;

    function automatic logic is_goto(input logic [PIC_INSTR_W-1:0] w);
        return w[13:11] == OP_GOTO_HI;
    endfunction

    function automatic logic is_call(input logic [PIC_INSTR_W-1:0] w);
        return w[13:11] == OP_CALL_HI;
    endfunction

    function automatic logic is_ret(input logic [PIC_INSTR_W-1:0] w);
        return (w == OP_RETURN) || (w == OP_RETFIE) || (w[13:10] == OP_RETLW_HI);
    endfunction

endpackage

// File: rtl/pic_return_stack.sv
// Circular hardware return stack: overflow overwrites the oldest entry, underflow
// reuses the wrapped entry; both conditions latch a sticky flag until reset.
module pic_return_stack
    import pic_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = PIC_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] push_data_i,
    output logic [DATA_W-1:0] pop_data_c_o,
    output logic              ovf_o,
    output logic              unf_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  sp_q, sp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    always_comb begin
        sp_d  = sp_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (push_i) begin
            sp_d = sp_q + PTR_W'(1);
            if (cnt_q == CNT_W'(DEPTH)) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop_i) begin
            sp_d = sp_q - PTR_W'(1);
            if (cnt_q == '0) begin
                unf_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Entry storage carries no reset; contents are meaningless until pushed.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[sp_q] <= push_data_i;
        end
    end

    assign pop_data_c_o = mem_q[sp_q - PTR_W'(1)];
    assign ovf_o        = ovf_q;
    assign unf_o        = unf_q;

endmodule

// File: rtl/pic_fetch_unit.sv
// PIC16-style fetch front end: PC, instruction register and return stack, resolving
// GOTO/CALL/returns and execute-requested skips with one bubble per redirect.
module pic_fetch_unit
    import pic_pkg::*;
#(
    parameter int unsigned       ADDR_W      = PIC_ADDR_W,
    parameter int unsigned       INSTR_W     = PIC_INSTR_W,
    parameter int unsigned       STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  Rom_addr_out,
    input  logic [INSTR_W-1:0] Rom_data_in,
    input  logic               stall,
    input  logic               skip,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               stack_ovf,
    output logic               stack_unf
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               ir_valid_q, ir_valid_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
    logic               push_c, pop_c;
    logic [ADDR_W-1:0]  pop_data_c;

    pic_return_stack #(
        .DEPTH  (STACK_DEPTH),
        .DATA_W (ADDR_W)
    ) u_stack (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push_c),
        .pop_i        (pop_c),
        .push_data_i  (pc_q),
        .pop_data_c_o (pop_data_c),
        .ovf_o        (stack_ovf),
        .unf_o        (stack_unf)
    );

    // Next-state: redirects decode the held IR and discard the word fetched this cycle.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        ir_pc_d    = ir_pc_q;
        push_c     = 1'b0;
        pop_c      = 1'b0;
        if (!stall) begin
            case (state_q)
                FILL: begin
                    ir_d       = Rom_data_in;
                    ir_valid_d = 1'b1;
                    ir_pc_d    = pc_q;
                    pc_d       = pc_q + ADDR_W'(1);
                    state_d    = RUN;
                end
                RUN: begin
                    if (ir_valid_q && (is_goto(ir_q) || is_call(ir_q))) begin
                        pc_d       = ir_q[ADDR_W-1:0];
                        push_c     = is_call(ir_q);
                        ir_d       = INSTR_W'(OP_NOP);
                        ir_valid_d = 1'b0;
                    end else if (ir_valid_q && is_ret(ir_q)) begin
                        pc_d       = pop_data_c;
                        pop_c      = 1'b1;
                        ir_d       = INSTR_W'(OP_NOP);
                        ir_valid_d = 1'b0;
                    end else begin
                        ir_d       = skip ? INSTR_W'(OP_NOP) : Rom_data_in;
                        ir_valid_d = ~skip;
                        ir_pc_d    = pc_q;
                        pc_d       = pc_q + ADDR_W'(1);
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            pc_q       <= RESET_VEC;
            ir_q       <= INSTR_W'(OP_NOP);
            ir_valid_q <= 1'b0;
            ir_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            ir_pc_q    <= ir_pc_d;
        end
    end

    assign Rom_addr_out = pc_q;
    assign ir           = ir_q;
    assign ir_valid     = ir_valid_q;
    assign ir_pc        = ir_pc_q;

endmodule

// File: doc/pic_fetch_unit.md
Name: pic_fetch_unit

Overview:
- Instruction-fetch front end for the 14-bit PIC16-style core.
- Drives the 11-bit program ROM address and reads the 14-bit word returned combinationally in the same cycle.
- Holds the program counter, the instruction register and an 8-level hardware return stack.
- Resolves GOTO/CALL/RETURN/RETLW/RETFIE redirects and execute-requested skips locally, then hands one instruction per cycle to the execute stage.

Parameters:
- ADDR_W, 11, program address width.
- INSTR_W, 14, instruction width.
- STACK_DEPTH, 8, return stack entries (power of two).
- RESET_VEC, 11'h000, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Rom_addr_out  out  ADDR_W  ROM address, equal to the PC register.
- Rom_data_in  in  INSTR_W  ROM word for Rom_addr_out, valid in the same cycle.
- stall  in  1  execute not ready; hold all fetch state.
- skip  in  1  execute requests that the instruction being fetched this cycle is squashed.
- ir  out  INSTR_W  instruction presented to execute.
- ir_valid  out  1  ir is a real instruction, not a bubble.
- ir_pc  out  ADDR_W  address of ir.
- stack_ovf  out  1  sticky: push with stack full.
- stack_unf  out  1  sticky: pop with stack empty.

Behaviour:
- Reset (asynchronous, any time, including mid-redirect):
  - PC=RESET_VEC; ir=14'h0000 (NOP); ir_valid=0; ir_pc=0.
  - sp=0, count=0; both sticky flags=0; stack contents are don't-care.
  - FSM=FILL.
- FSM states:
  - FILL: first cycle after reset. IR<=ROM[PC]; ir_valid<=1; PC<=PC+1; next state RUN.
  - RUN: normal operation.
  - Stall overrides both states: no state change.
- Decode of ir, RUN only, only when ir_valid=1:
  - GOTO: ir[13:11]=3'b101. Target = ir[10:0].
  - CALL: ir[13:11]=3'b100. Target = ir[10:0]; push PC.
  - RETURN: ir=14'h0008. Pop.
  - RETFIE: ir=14'h0009. Pop.
  - RETLW: ir[13:10]=4'b1101. Pop.
- RUN cycle with stall=0, no redirect:
  - IR<=Rom_data_in; ir_pc<=PC; PC<=PC+1, wrapping 11'h7FF->11'h000.
  - ir_valid<=~skip. When skip=1, IR<=NOP.
- Redirect cycle:
  - PC<=target (or popped value); IR<=NOP; ir_valid<=0. The fetched word is discarded.
  - Result: one bubble per redirect, so a branch costs 2 cycles.
- CALL push:
  - stack[sp]<=PC, where PC is already call_addr+1.
  - sp<=sp+1 mod STACK_DEPTH.
  - If count==STACK_DEPTH: oldest entry overwritten and stack_ovf<=1; otherwise count++.
- Pop (RETURN/RETFIE/RETLW):
  - PC<=stack[sp-1]; sp<=sp-1 mod depth.
  - If count==0: stack_unf<=1 and the wrapped entry is still used; otherwise count--.
- skip together with a redirect: the redirect wins and skip is ignored (the squashed word is discarded anyway).
- stall=1: PC, IR, ir_valid, ir_pc, sp, count and flags all hold. skip and redirect are not evaluated; execute holds skip until stall drops.
- Rom_addr_out is purely the PC register, with no combinational path from inputs.
- Sticky flags clear only on reset.

Decomposition:
- pic_pkg holds: ADDR_W/INSTR_W constants; NOP, RETURN and RETFIE opcodes; GOTO/CALL/RETLW opcode masks; fetch_state_e enum {FILL, RUN}; and is_goto/is_call/is_ret functions.
- Sub-module pic_return_stack: push/pop/data, circular pointer, count, and ovf/unf flags.

Test Plan:
1. Linear flow: ROM 0:3001, 1:3E02, 2:3003, 3:3004; release reset.
   - Rom_addr_out 0,1,2,3…
   - ir_valid rises 1 cycle after reset release.
   - ir sequence 3001, 3E02, 3003, 3004 with ir_pc 0..3.
2. GOTO: ROM 2:2C10 (GOTO 0x410), 0x410:3055.
   - After ir=2C10: one cycle ir_valid=0, then ir=3055 with ir_pc=0x410.
   - The word at 3 never has ir_valid=1.
3. CALL/RETURN: ROM 5:2020 (CALL 0x020), 0x20:3011, 0x21:0008, 6:3077.
   - ir sequence 2020, bubble, 3011, 0008, bubble, 3077 with ir_pc=6.
4. Skip and stall:
   - skip=1 for one cycle while ir=3001 at ir_pc=0 → next ir is a bubble and the following ir_pc=2.
   - stall=1 for 3 cycles → ir and Rom_addr_out frozen.
5. Stack limits:
   - 9 nested CALLs → stack_ovf=1 after the 9th; the 9th RETURN lands on the 9th return address (wrapped).
   - RETURN with empty stack after reset → stack_unf=1.
6. Mid-redirect reset: assert rst_n=0 in the bubble cycle after a GOTO → immediately PC=0, ir_valid=0, flags=0; FILL on release.
